// File: rtl/vga_scanout_pkg.sv
// micro1 video constants: raster timing, line-buffer geometry, widths.
// Shared by the scanout top, its line buffer and its bus interface.
package micro1_video_pkg;
  localparam int H_TOTAL        = 3200;
  localparam int H_ACTIVE       = 2560;
  localparam int H_SYNC_START   = 2700;
  localparam int H_SYNC_END     = 3000;
  localparam int V_TOTAL        = 525;
  localparam int V_SYNC_LINES   = 2;
  localparam int V_ACTIVE_START = 35;
  localparam int ROW_LINES      = 16;
  localparam int N_ROWS         = 30;
  localparam int ROW_WORDS      = 20;
  localparam int H_W            = 12;
  localparam int L_W            = 10;
  localparam int IDX_W          = 5;
  localparam int ROW_W          = 5;
  localparam int WORD_W         = 16;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [IDX_W-1:0]     idx_t;
  typedef logic [ROW_W-1:0]     row_t;
  typedef logic [ROW_WORDS-1:0] mask_t;
endpackage

// File: rtl/vga_scanout_if.sv
// Memory-controller side bus: line-buffer writes in, fetch requests out.
// master = memory controller, slave = vga_scanout.
interface vga_scanout_if;
  logic                   wr_valid;
  micro1_video_pkg::idx_t wr_index;
  micro1_video_pkg::word_t wr_data;
  logic                   fetch_start;
  micro1_video_pkg::row_t fetch_row;
  logic                   fetch_underrun;

  modport master (
    output wr_valid, wr_index, wr_data,
    input  fetch_start, fetch_row, fetch_underrun
  );
  modport slave (
    input  wr_valid, wr_index, wr_data,
    output fetch_start, fetch_row, fetch_underrun
  );
endinterface

// File: rtl/vga_scanout_line_buffer.sv
// Double-banked 20x16 line buffer: writes to back, reads front, valid mask.
// Ports: clk, rst_n, we/wr_idx/wr_data, swap, rd_idx -> rd_word, mask_full.
module vga_line_buffer
  import micro1_video_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we,
  input  idx_t  wr_idx,
  input  word_t wr_data,
  input  logic  swap,
  input  idx_t  rd_idx,
  output word_t rd_word,
  output logic  mask_full
);
  word_t mem [2][ROW_WORDS];
  mask_t mask;
  mask_t wr_bit;
  logic  sel;
  logic  rsel;

  always_comb begin
    wr_bit = '0;
    if (we) wr_bit = mask_t'(1) << wr_idx;
  end

  // A write on the swap cycle still counts toward the outgoing back bank.
  assign mask_full = &(mask | wr_bit);

  // On the swap cycle the pixel already comes from the bank becoming front,
  // with the simultaneous write forwarded.
  assign rsel = swap ? ~sel : sel;

  always_comb begin
    rd_word = '0;
    if (rd_idx < IDX_W'(ROW_WORDS))
      rd_word = mem[rsel][rd_idx];
    if (swap && we && wr_idx == rd_idx)
      rd_word = wr_data;
  end

  always_ff @(posedge clk) begin
    if (we) mem[~sel][wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel  <= 1'b0;
      mask <= '0;
    end else if (swap) begin
      sel  <= ~sel;
      mask <= '0;
    end else begin
      mask <= mask | wr_bit;
    end
  end
endmodule

// File: rtl/vga_scanout.sv
// micro1 VGA scanout: raster counters, row fetch/swap, 1bpp serializer.
// Ports: clk_100mhz, rst_n, ena, bus (slave), vga_hs/vs/de/pix.
module vga_scanout #(
  parameter int H_TOTAL        = micro1_video_pkg::H_TOTAL,
  parameter int H_ACTIVE       = micro1_video_pkg::H_ACTIVE,
  parameter int H_SYNC_START   = micro1_video_pkg::H_SYNC_START,
  parameter int H_SYNC_END     = micro1_video_pkg::H_SYNC_END,
  parameter int V_TOTAL        = micro1_video_pkg::V_TOTAL,
  parameter int V_SYNC_LINES   = micro1_video_pkg::V_SYNC_LINES,
  parameter int V_ACTIVE_START = micro1_video_pkg::V_ACTIVE_START,
  parameter int ROW_LINES      = micro1_video_pkg::ROW_LINES,
  parameter int N_ROWS         = micro1_video_pkg::N_ROWS
) (
  input  logic         clk_100mhz,
  input  logic         rst_n,
  input  logic         ena,
  vga_scanout_if.slave bus,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         vga_de,
  output logic         vga_pix
);
  import micro1_video_pkg::H_W;
  import micro1_video_pkg::L_W;
  import micro1_video_pkg::IDX_W;
  import micro1_video_pkg::ROW_WORDS;
  import micro1_video_pkg::word_t;
  import micro1_video_pkg::idx_t;
  import micro1_video_pkg::row_t;

  localparam int RL_W = $clog2(ROW_LINES);
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_LO  = H_W'(H_SYNC_START);
  localparam logic [H_W-1:0] HS_HI  = H_W'(H_SYNC_END);
  localparam logic [L_W-1:0] L_LAST = L_W'(V_TOTAL - 1);
  localparam logic [L_W-1:0] VS_END = L_W'(V_SYNC_LINES);
  localparam logic [L_W-1:0] V_ACT  = L_W'(V_ACTIVE_START);
  localparam logic [L_W-1:0] F_1ST  =
    L_W'(V_ACTIVE_START - ROW_LINES);
  localparam logic [L_W-1:0] SPAN   = L_W'(N_ROWS * ROW_LINES);
  localparam idx_t IDX_LIM = IDX_W'(ROW_WORDS);

  logic [H_W-1:0] h;
  logic [L_W-1:0] line;
  logic [L_W-1:0] f_off;
  logic [L_W-1:0] s_off;
  logic           fetch_now;
  logic           swap_now;
  logic           active;
  logic           we;
  logic           mask_full;
  idx_t           rd_idx;
  word_t          rd_word;

  // Offsets wrap to large values above the window, so one compare
  // bounds both ends.
  assign f_off = line - F_1ST;
  assign s_off = line - V_ACT;

  assign fetch_now = h == '0 && f_off < SPAN
                  && f_off[RL_W-1:0] == '0;
  assign swap_now  = ena && h == '0 && s_off < SPAN
                  && s_off[RL_W-1:0] == '0;
  assign active    = s_off < SPAN && h < H_ACT;
  assign we        = ena && bus.wr_valid
                  && bus.wr_index < IDX_LIM;

  // 8 clk per pixel, 16 pixels per word.
  assign rd_idx = IDX_W'(h >> 7);

  vga_line_buffer u_lbuf (
    .clk       (clk_100mhz),
    .rst_n     (rst_n),
    .we        (we),
    .wr_idx    (bus.wr_index),
    .wr_data   (bus.wr_data),
    .swap      (swap_now),
    .rd_idx    (rd_idx),
    .rd_word   (rd_word),
    .mask_full (mask_full)
  );

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      h    <= '0;
      line <= '0;
    end else if (ena) begin
      if (h == H_LAST) begin
        h    <= '0;
        line <= (line == L_LAST) ? '0 : line + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs             <= 1'b1;
      vga_vs             <= 1'b0;
      vga_de             <= 1'b0;
      vga_pix            <= 1'b0;
      bus.fetch_start    <= 1'b0;
      bus.fetch_row      <= '0;
      bus.fetch_underrun <= 1'b0;
    end else begin
      bus.fetch_start <= 1'b0;
      if (ena) begin
        vga_hs  <= !(h >= HS_LO && h <= HS_HI);
        vga_vs  <= line >= VS_END;
        vga_de  <= active;
        vga_pix <= active && rd_word[h[6:3]];
        bus.fetch_start <= fetch_now;
        if (fetch_now)
          bus.fetch_row <= row_t'(f_off >> RL_W);
        if (swap_now && !mask_full)
          bus.fetch_underrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: scaled raster instance plus a
// default-timing instance for the real line timing.
module tb_vga_scanout;
  logic clk;
  logic s_rst_n, d_rst_n, s_ena;
  logic s_hs, s_vs, s_de, s_pix;
  logic d_hs, d_vs, d_de, d_pix;
  int checks = 0;
  int failures = 0;

  vga_scanout_if sif ();
  vga_scanout_if dif ();

  // Scaled: 320 clk/line, 24 lines, rows of 4 lines, 3 rows.
  // Fetch lines 4,8,12; swap lines 8,12,16; active lines 8..19.
  vga_scanout #(
    .H_TOTAL(320), .H_ACTIVE(256),
    .H_SYNC_START(270), .H_SYNC_END(300),
    .V_TOTAL(24), .V_SYNC_LINES(2),
    .V_ACTIVE_START(8), .ROW_LINES(4), .N_ROWS(3)
  ) u_s (
    .clk_100mhz(clk), .rst_n(s_rst_n), .ena(s_ena),
    .bus(sif.slave),
    .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_de(s_de), .vga_pix(s_pix)
  );

  vga_scanout u_d (
    .clk_100mhz(clk), .rst_n(d_rst_n), .ena(1'b1),
    .bus(dif.slave),
    .vga_hs(d_hs), .vga_vs(d_vs),
    .vga_de(d_de), .vga_pix(d_pix)
  );

  always #5 clk = ~clk;

  int pe = 0;
  int dpe = 0;
  always @(posedge clk) begin
    if (!s_rst_n) pe <= 0; else pe <= pe + 1;
    if (!d_rst_n) dpe <= 0; else dpe <= dpe + 1;
  end

  int hs_low = 0, hs_bad = 0, vs_low = 0, vs_bad = 0;
  int de_cnt = 0, de_bad = 0, pix_cnt = 0, fs_cnt = 0;
  int fs_n [16];
  int fs_row [16];
  logic [255:0] pix8 = '0;

  // Outputs seen after posedge number pe reflect counter state pe-1.
  always @(posedge clk) begin
    int n, mh, ml;
    #1;
    if (s_rst_n && pe > 0) begin
      n  = pe - 1;
      mh = n % 320;
      ml = (n / 320) % 24;
      if (!s_hs) hs_low++;
      if (!s_hs && (mh < 270 || mh > 300)) hs_bad++;
      if (!s_vs) vs_low++;
      if (s_vs != (ml >= 2)) vs_bad++;
      if (s_de) de_cnt++;
      if (s_de != (ml >= 8 && ml < 20 && mh < 256)) de_bad++;
      if (s_pix) pix_cnt++;
      if (ml == 8 && mh < 256) pix8[mh] = s_pix;
      if (sif.fetch_start) begin
        if (fs_cnt < 16) begin
          fs_n[fs_cnt]   = n;
          fs_row[fs_cnt] = int'(sif.fetch_row);
        end
        fs_cnt++;
      end
    end
  end

  int d_hs_low = 0, d_hmin = 99999, d_hmax = -1;
  int d_vs_low = 0, d_de_cnt = 0, d_fs = 0;
  always @(posedge clk) begin
    int n, mh;
    #1;
    if (d_rst_n && dpe > 0 && dpe <= 9600) begin
      n  = dpe - 1;
      mh = n % 3200;
      if (!d_hs) begin
        d_hs_low++;
        if (mh < d_hmin) d_hmin = mh;
        if (mh > d_hmax) d_hmax = mh;
      end
      if (!d_vs) d_vs_low++;
      if (d_de) d_de_cnt++;
      if (dif.fetch_start) d_fs++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_pe(input int t);
    while (pe < t) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] i, input logic [15:0] d);
    sif.wr_valid = 1'b1;
    sif.wr_index = i;
    sif.wr_data  = d;
    @(negedge clk);
    sif.wr_valid = 1'b0;
  endtask

  task automatic wr_row(input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] rest, input int skip);
    for (int i = 0; i < 20; i++)
      if (i != skip)
        wr(5'(i), i == 0 ? w0 : (i == 1 ? w1 : rest));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_hs"}, s_hs, 1);
    chk({tag, "_vs"}, s_vs, 0);
    chk({tag, "_de"}, s_de, 0);
    chk({tag, "_pix"}, s_pix, 0);
    chk({tag, "_fs"}, sif.fetch_start, 0);
    chk({tag, "_row"}, sif.fetch_row, 0);
    chk({tag, "_unr"}, sif.fetch_underrun, 0);
  endtask

  task automatic chk_frz(input string tag);
    chk({tag, "_hs"}, s_hs, 1);
    chk({tag, "_vs"}, s_vs, 1);
    chk({tag, "_de"}, s_de, 1);
    chk({tag, "_pix"}, s_pix, 1);
    chk({tag, "_fs"}, sif.fetch_start, 0);
    chk({tag, "_row"}, sif.fetch_row, 1);
    chk({tag, "_unr"}, sif.fetch_underrun, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [255:0] e0, e1;
    int b;
    for (int i = 0; i < 256; i++) begin
      e0[i] = (i < 8) || (i >= 248);
      e1[i] = (i >= 192) && (i < 200);
    end
    clk = 0;
    s_rst_n = 0;
    d_rst_n = 0;
    s_ena = 1;
    sif.wr_valid = 0;
    sif.wr_index = '0;
    sif.wr_data  = '0;
    dif.wr_valid = 0;
    dif.wr_index = '0;
    dif.wr_data  = '0;
    repeat (3) @(negedge clk);
    chk_rst("rst");
    chk("d_rst_hs", d_hs, 1);
    chk("d_rst_vs", d_vs, 0);
    chk("d_rst_de", d_de, 0);
    s_rst_n = 1;
    d_rst_n = 1;

    // Frame 0: one complete row per fetch.
    wait_pe(1300);
    wr_row(16'h0001, 16'h8000, 16'h0000, -1);
    wait_pe(2600);
    wr_row(16'h0000, 16'h00F0, 16'h0000, -1);
    wait_pe(3900);
    wr_row(16'hFFFF, 16'h0000, 16'h0000, -1);
    wait_pe(7680);
    chk("hs_low", hs_low, 744);
    chk("hs_pos", hs_bad, 0);
    chk("vs_low", vs_low, 640);
    chk("vs_pos", vs_bad, 0);
    chk("de_cnt", de_cnt, 3072);
    chk("de_pos", de_bad, 0);
    chk("fs_cnt", fs_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      chk("fs_at", fs_n[i], (4 + 4 * i) * 320);
      chk("fs_row", fs_row[i], i);
    end
    chk("pix_cnt", pix_cnt, 704);
    chk("pix8_f0", pix8, e0);
    chk("unr_f0", sif.fetch_underrun, 0);

    // Frame 1: word 1 only written on the swap cycle itself.
    b = pix_cnt;
    wait_pe(8980);
    wr_row(16'h0000, 16'h0000, 16'h0000, 1);
    wait_pe(9600);
    chk("d_hs_low", d_hs_low, 903);
    chk("d_hs_min", d_hmin, 2700);
    chk("d_hs_max", d_hmax, 3000);
    chk("d_vs_low", d_vs_low, 6400);
    chk("d_de_cnt", d_de_cnt, 0);
    chk("d_fs", d_fs, 0);
    wait_pe(10240);
    wr(5'd1, 16'h0100);
    wait_pe(10280);
    wr_row(16'h0000, 16'h0000, 16'h0000, -1);
    wait_pe(11580);
    wr_row(16'h0000, 16'h0000, 16'h0000, -1);
    wait_pe(15360);
    chk("f1_fs_cnt", fs_cnt, 6);
    chk("f1_fs_at", fs_n[4], 10240);
    chk("pix8_swapwr", pix8, e1);
    chk("f1_pix", pix_cnt - b, 32);
    chk("unr_f1", sif.fetch_underrun, 0);

    // Frame 2: word 19 missing, index 20 must not stand in for it.
    wait_pe(16660);
    wr_row(16'hFFFF, 16'hFFFF, 16'hFFFF, 19);
    wr(5'd20, 16'hFFFF);
    wait_pe(17920);
    chk("unr_pre", sif.fetch_underrun, 0);
    @(negedge clk);
    chk("unr_post", sif.fetch_underrun, 1);

    // Freeze at line 9, h 100 for 100 clocks.
    wait_pe(18341);
    chk_frz("frz0");
    b = fs_cnt;
    s_ena = 0;
    repeat (100) @(negedge clk);
    chk_frz("frz1");
    chk("frz_fs", fs_cnt - b, 0);
    s_ena = 1;
    wait_pe(19400);
    chk("thaw_fs", fs_cnt - b, 1);
    chk("thaw_at", fs_n[b], 19300);
    chk("thaw_row", fs_row[b], 2);
    chk("unr_stk", sif.fetch_underrun, 1);

    // Mid-frame async reset.
    wait_pe(19600);
    chk("pre_rst_row", sif.fetch_row, 2);
    s_rst_n = 0;
    #1;
    chk_rst("mid");
    repeat (3) @(negedge clk);
    s_rst_n = 1;
    b = fs_cnt;
    wait_pe(1400);
    chk("rs_fs", fs_cnt - b, 1);
    chk("rs_at", fs_n[b], 1280);
    chk("rs_row", fs_row[b], 0);
    chk("rs_unr", sif.fetch_underrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
